sram_bus_arbiter: RTL

Shares the single external SRAM port between instruction fetch (read-only) and the MEM stage's data request (`mem_address`/`mem_load`/`mem_store`/`mem_wdata`/`mem_byte_en`).
- Arbitrates with fixed priority to MEM.
- Latches the granted request and sequences async-SRAM control timing over a fixed number of wait cycles.
- Returns read data with a one-cycle ready pulse, and drives per-requester stall to pipeline control.

---
 rtl/sram_bus_arbiter_pkg.sv | 42 ++++
 rtl/sram_bus_arbiter_seq.sv | 90 +++++++++
 rtl/sram_bus_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the SRAM bus arbiter: FSM states, grant encoding, the
// latched request record and the write-strobe timing helper.
package sram_bus_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic        bit_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_IF,
    GRANT_MEM
  } grant_t;

  typedef struct packed {
    word_t       addr;
    word_t       wdata;
    logic [3:0]  be;
    bit_t        we;
  } sram_req_t;

  // Reads always fetch the full word; lane selection happens downstream.
  localparam logic [3:0] BE_FULL = 4'b1111;
  // All byte lanes deselected on the active-low SRAM pins.
  localparam logic [3:0] BE_N_IDLE = 4'b1111;

  // True when we_n must be low in ACCESS cycle `cnt`. Cycle 0 is address
  // setup and the last cycle is data hold. With only two ACCESS cycles the
  // hold moves into DONE (data is still driven there), so cycle 1 strobes.
  function automatic bit_t we_strobe(input int unsigned cnt,
                                     input int unsigned wait_cycles);
    if (cnt == 0) return 1'b0;
    if (wait_cycles == 2) return 1'b1;
    return bit_t'(cnt < wait_cycles - 1);
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_seq.sv
// Async-SRAM access sequencer: latches a granted request on start, walks the
// ACCESS counter and drives registered SRAM pins, flags the last ACCESS cycle.
module sram_access_seq
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  sram_req_t          req,
  output logic               done,
  output word_t              rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output word_t              sram_wdata,
  output logic               sram_wdata_en,
  input  word_t              sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam int unsigned          CNT_W    = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  bit_t             we_q;
  logic             unused_addr_bits;

  assign cnt_nxt = cnt_q + CNT_W'(1);
  // Last ACCESS cycle: the arbiter captures read data and moves to DONE here.
  assign done    = active_q && (cnt_q == CNT_LAST);
  // The data bus word sampled at the edge that ends the last ACCESS cycle.
  assign rdata   = sram_rdata;
  // Byte offset and bits above the SRAM word range never reach the pins.
  assign unused_addr_bits = ^{req.addr[31:SRAM_AW+2], req.addr[1:0]};

  // Access counter and latched write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      we_q     <= req.we;
    end else if (active_q) begin
      if (done) active_q <= 1'b0;
      else      cnt_q    <= cnt_nxt;
    end
  end

  // Registered SRAM pins, loaded with the value for the coming cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_wdata_en <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_be_n     <= BE_N_IDLE;
    end else if (start) begin
      sram_addr     <= req.addr[SRAM_AW+1:2];
      sram_wdata    <= req.wdata;
      sram_wdata_en <= req.we;
      sram_ce_n     <= 1'b0;
      sram_oe_n     <= req.we;
      sram_we_n     <= 1'b1;
      sram_be_n     <= ~req.be;
    end else if (done) begin
      // DONE: deselect the chip but keep driving write data for hold.
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_be_n     <= BE_N_IDLE;
      sram_wdata_en <= we_q;
    end else if (active_q) begin
      sram_we_n     <= ~(we_q && we_strobe(32'(cnt_nxt), WAIT_CYCLES));
    end else begin
      sram_wdata_en <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one async SRAM port between instruction fetch and the MEM stage.
// MEM has fixed priority; each grant runs a full IDLE/ACCESS/DONE sequence.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  output logic               if_stall,
  input  logic               mem_load,
  input  logic               mem_store,
  input  logic [31:0]        mem_address,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_byte_en,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               mem_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               sram_wdata_en,
  input  logic [31:0]        sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  arb_state_t state_q, state_d;
  grant_t     grant_q, grant_d;
  sram_req_t  req_d;
  logic       start;
  logic       mem_req;
  logic       seq_done;
  word_t      seq_rdata;
  bit_t       mem_we_q;
  logic       if_ready_q, mem_ready_q;
  word_t      if_rdata_q, mem_rdata_q;

  assign mem_req = mem_load | mem_store;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: DONE always returns to IDLE, so every request pays in full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = ACCESS;
      ACCESS:  if (seq_done) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs: fixed-priority grant and the request record to latch.
  always_comb begin
    start    = 1'b0;
    grant_d  = GRANT_NONE;
    req_d    = '0;
    req_d.be = BE_FULL;
    if (state_q == IDLE) begin
      if (mem_req) begin
        // Load and store together is treated as a store.
        start       = 1'b1;
        grant_d     = GRANT_MEM;
        req_d.addr  = mem_address;
        req_d.wdata = mem_wdata;
        req_d.we    = mem_store;
        req_d.be    = mem_store ? mem_byte_en : BE_FULL;
      end else if (if_req) begin
        start      = 1'b1;
        grant_d    = GRANT_IF;
        req_d.addr = if_addr;
      end
    end
  end

  // Grant tracking, ready pulses and per-requester read data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q     <= GRANT_NONE;
      mem_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (start) begin
        grant_q  <= grant_d;
        mem_we_q <= req_d.we;
      end else if (state_q == DONE) begin
        grant_q  <= GRANT_NONE;
      end
      if ((state_q == ACCESS) && seq_done) begin
        if (grant_q == GRANT_IF) begin
          if_ready_q <= 1'b1;
          if_rdata_q <= seq_rdata;
        end
        if (grant_q == GRANT_MEM) begin
          mem_ready_q <= 1'b1;
          if (!mem_we_q) mem_rdata_q <= seq_rdata;
        end
      end
    end
  end

  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign mem_stall = mem_req & ~mem_ready_q;

  sram_access_seq #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .SRAM_AW     (SRAM_AW)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .req           (req_d),
    .done          (seq_done),
    .rdata         (seq_rdata),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_wdata_en (sram_wdata_en),
    .sram_rdata    (sram_rdata),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_be_n     (sram_be_n)
  );

endmodule
